// File: rtl/ook_frame_sync_checker.sv
// Receive-side frame synchroniser and PRBS checker for an OOK link.
//
// Hunts the recovered bit stream for a 10-bit frame header, then warms up a
// self-synchronising PRBS checker on the first POLY_LENGTH payload bits and
// checks every following bit. Too many errors in one window drop lock and
// return to the header hunt.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   data_in         received OOK bit
//   data_valid      qualifier for data_in; all state holds while low
//   clear_counters  synchronous clear of bit_count, err_count, relock_count
//   frame_locked    high while warming up or checking payload
//   err_pulse       one-cycle pulse per errored checked bit
//   bit_count       checked payload bits, saturating
//   err_count       errored payload bits, saturating
//   relock_count    loss-of-lock events, saturating at 255
module ook_frame_sync_checker #(
  parameter bit          INV_PATTERN = 1'b0,
  parameter int unsigned POLY_LENGTH = 7,
  parameter int unsigned POLY_TAP    = 1,
  parameter logic [9:0]  HEADER      = 10'b1100110011,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned LOL_WINDOW  = 64,
  parameter int unsigned LOL_THRESH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 data_valid,
  input  logic                 clear_counters,
  output logic                 frame_locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [7:0]           relock_count
);

  localparam int unsigned L      = POLY_LENGTH;
  localparam int unsigned T      = POLY_TAP;
  localparam int unsigned WarmW  = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned WinW   = (LOL_WINDOW > 1) ? $clog2(LOL_WINDOW) : 1;
  localparam int unsigned ErrW   = $clog2(LOL_THRESH + 1);

  localparam int unsigned WarmLastI = L - 1;
  localparam int unsigned WinLastI  = LOL_WINDOW - 1;
  localparam logic [WarmW-1:0] WarmLast = WarmLastI[WarmW-1:0];
  localparam logic [WinW-1:0]  WinLast  = WinLastI[WinW-1:0];
  localparam logic [ErrW:0]    ThreshV  = LOL_THRESH[ErrW:0];

  typedef enum logic [1:0] {StHunt, StWarmup, StCheck} state_e;

  state_e               state_q, state_d;
  // Only the 9 most recent bits need storing; the 10th is data_in itself.
  logic [8:0]           hdr_sr_q, hdr_sr_d;
  logic [L-1:0]         hist_q, hist_d;
  logic [WarmW-1:0]     warm_cnt_q, warm_cnt_d;
  logic [WinW-1:0]      win_cnt_q, win_cnt_d;
  logic [ErrW-1:0]      win_err_q, win_err_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [7:0]           relock_count_q, relock_count_d;

  logic [9:0]  hdr_next;
  logic        err;
  logic [ErrW:0] win_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHunt;
      hdr_sr_q       <= '0;
      hist_q         <= '0;
      warm_cnt_q     <= '0;
      win_cnt_q      <= '0;
      win_err_q      <= '0;
      err_pulse_q    <= 1'b0;
      bit_count_q    <= '0;
      err_count_q    <= '0;
      relock_count_q <= '0;
    end else begin
      state_q        <= state_d;
      hdr_sr_q       <= hdr_sr_d;
      hist_q         <= hist_d;
      warm_cnt_q     <= warm_cnt_d;
      win_cnt_q      <= win_cnt_d;
      win_err_q      <= win_err_d;
      err_pulse_q    <= err_pulse_d;
      bit_count_q    <= bit_count_d;
      err_count_q    <= err_count_d;
      relock_count_q <= relock_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    hdr_sr_d       = hdr_sr_q;
    hist_d         = hist_q;
    warm_cnt_d     = warm_cnt_q;
    win_cnt_d      = win_cnt_q;
    win_err_d      = win_err_q;
    err_pulse_d    = 1'b0;
    bit_count_d    = bit_count_q;
    err_count_d    = err_count_q;
    relock_count_d = relock_count_q;
    hdr_next       = {hdr_sr_q, data_in};
    // Self-synchronising check: the received history stands in for the generator state.
    err            = data_in ^ hist_q[L-1] ^ hist_q[T-1] ^ INV_PATTERN;
    win_sum        = {1'b0, win_err_q} + {{ErrW{1'b0}}, err};

    if (data_valid) begin
      unique case (state_q)
        StHunt: begin
          hdr_sr_d = hdr_next[8:0];
          if (hdr_next == HEADER) begin
            state_d    = StWarmup;
            hist_d     = '0;
            warm_cnt_d = '0;
          end
        end
        StWarmup: begin
          hist_d = {hist_q[L-2:0], data_in};
          if (warm_cnt_q == WarmLast) begin
            state_d    = StCheck;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
        StCheck: begin
          hist_d      = {hist_q[L-2:0], data_in};
          err_pulse_d = err;
          if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
          if (err && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
          // Loss of lock wins over the end-of-window clear.
          if (win_sum >= ThreshV) begin
            state_d   = StHunt;
            hdr_sr_d  = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            if (relock_count_q != 8'hff) relock_count_d = relock_count_q + 8'd1;
          end else if (win_cnt_q == WinLast) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_sum[ErrW-1:0];
          end
        end
        default: state_d = StHunt;
      endcase
    end

    // Counter clear beats any same-cycle increment and ignores data_valid.
    if (clear_counters) begin
      bit_count_d    = '0;
      err_count_d    = '0;
      relock_count_d = '0;
    end
  end

  assign frame_locked = (state_q != StHunt);
  assign err_pulse    = err_pulse_q;
  assign bit_count    = bit_count_q;
  assign err_count    = err_count_q;
  assign relock_count = relock_count_q;

endmodule
